// File: rtl/cory_rr_arb.sv
// Packet-level round-robin arbiter: shares one valid/ready channel among M requesters,
// holding each grant for exactly L accepted beats before rotating priority.
module cory_rr_arb #(
    parameter int unsigned N = 64,
    parameter int unsigned M = 4,
    parameter int unsigned L = 16,
    parameter int unsigned W = $clog2(M)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [M-1:0]   i_a_v,
    input  logic [M*N-1:0] i_a_d,
    output logic [M-1:0]   o_a_r,
    output logic           o_z_v,
    output logic [N-1:0]   o_z_d,
    output logic [W-1:0]   o_z_s,
    output logic           o_z_l,
    input  logic           i_z_r,
    output logic           o_busy
);

    localparam int unsigned   CW       = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic [W-1:0]  grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          busy;
    logic          any_req;
    logic          fire;
    logic          last;
    logic [W-1:0]  pick;
    int unsigned   rr_idx;

    assign busy    = (state_q == BUSY);
    assign any_req = |i_a_v;
    assign last    = (cnt_q == CNT_LAST);
    assign fire    = busy && i_a_v[grant_q] && i_z_r;

    // First requester at or after ptr, wrapping modulo M; lowest offset wins.
    always_comb begin
        pick   = ptr_q;
        rr_idx = 0;
        for (int unsigned i = M; i > 0; i--) begin
            rr_idx = 32'(ptr_q) + i - 1;
            if (rr_idx >= M) begin
                rr_idx = rr_idx - M;
            end
            if (i_a_v[W'(rr_idx)]) begin
                pick = W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (fire) begin
                    if (last) begin
                        ptr_d   = (grant_q == W'(M - 1)) ? '0 : grant_q + W'(1);
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Channel is a pass-through of the granted requester while a packet is open.
    assign o_busy = busy;
    assign o_z_s  = grant_q;
    assign o_z_v  = busy && i_a_v[grant_q];
    assign o_z_d  = busy ? i_a_d[grant_q*N +: N] : '0;
    assign o_z_l  = busy && last;
    assign o_a_r  = (busy && i_z_r) ? (M'(1) << grant_q) : '0;

endmodule

// File: tb/tb_cory_rr_arb.sv
// Directed bench for cory_rr_arb: reset, single source, rotation, wrap, backpressure,
// mid-packet reset, plus an L=1 / M=3 instance for per-beat rotation.
module tb_cory_rr_arb;

    localparam int unsigned N = 16;
    localparam int unsigned M = 4;
    localparam int unsigned L = 16;
    localparam int unsigned W = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [M-1:0]   i_a_v;
    logic [M*N-1:0] i_a_d;
    logic [M-1:0]   o_a_r;
    logic           o_z_v;
    logic [N-1:0]   o_z_d;
    logic [W-1:0]   o_z_s;
    logic           o_z_l;
    logic           i_z_r;
    logic           o_busy;

    logic [2:0]     l1_ar;
    logic           l1_zv;
    logic [7:0]     l1_zd;
    logic [1:0]     l1_zs;
    logic           l1_zl;
    logic           l1_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cory_rr_arb #(.N(N), .M(M), .L(L)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
        .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_s(o_z_s), .o_z_l(o_z_l),
        .i_z_r(i_z_r), .o_busy(o_busy)
    );

    cory_rr_arb #(.N(8), .M(3), .L(1)) u_l1 (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(3'b111), .i_a_d(24'h302010), .o_a_r(l1_ar),
        .o_z_v(l1_zv), .o_z_d(l1_zd), .o_z_s(l1_zs), .o_z_l(l1_zl),
        .i_z_r(1'b1), .o_busy(l1_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Source k presents {k, sequence number}; sequence advances on its own input handshake.
    logic [11:0] gen_seq [M];
    logic [11:0] exp_seq [M];
    logic [M-1:0] ihs;

    always_comb begin
        for (int k = 0; k < M; k++) begin
            i_a_d[k*N +: N] = {4'(k), gen_seq[k]};
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < M; k++) gen_seq[k] <= '0;
        end else begin
            for (int k = 0; k < M; k++) gen_seq[k] <= gen_seq[k] + 12'(ihs[k]);
        end
    end

    function automatic logic [W-1:0] rr_model(input logic [W-1:0] p, input logic [M-1:0] v);
        logic [W-1:0] r;
        logic found;
        int j;
        r = p;
        found = 1'b0;
        for (int i = 0; i < M; i++) begin
            j = (int'(p) + i) % M;
            if (!found && v[j]) begin
                r = W'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    logic [W-1:0] mptr, exp_grant, prev_s;
    logic         prev_busy, prev_stall, prev_lastfire;
    logic [N-1:0] prev_d;
    int           beat;
    logic [W-1:0] grants [$];

    always @(negedge clk) begin
        logic fire, lf;
        ihs = reset_n ? (o_a_r & i_a_v) : '0;
        if (!reset_n) begin
            for (int k = 0; k < M; k++) exp_seq[k] = '0;
            mptr = '0; exp_grant = '0; prev_s = '0; prev_d = '0;
            prev_busy = 1'b0; prev_stall = 1'b0; prev_lastfire = 1'b0;
            beat = 0;
            grants.delete();
        end else begin
            if (o_busy && !prev_busy) begin
                check("grant", 64'(o_z_s), 64'(exp_grant));
                grants.push_back(o_z_s);
            end
            if (prev_lastfire) check("gap_idle", 64'(o_busy), 64'(0));
            if (!o_busy) begin
                check("idle_v", 64'(o_z_v), 64'(0));
                check("idle_d", 64'(o_z_d), 64'(0));
                check("idle_ar", 64'(o_a_r), 64'(0));
            end else begin
                check("ar_sel", 64'(o_a_r), i_z_r ? (64'(1) << o_z_s) : 64'(0));
                check("last_flag", 64'(o_z_l), 64'(beat == L - 1));
            end
            if (prev_stall && i_a_v[prev_s]) begin
                check("stall_v", 64'(o_z_v), 64'(1));
                check("stall_d", 64'(o_z_d), 64'(prev_d));
            end
            fire = o_z_v && i_z_r;
            lf   = fire && (beat == L - 1);
            if (fire) begin
                check("data", 64'(o_z_d), 64'({4'(o_z_s), exp_seq[o_z_s]}));
                exp_seq[o_z_s] = exp_seq[o_z_s] + 12'd1;
                if (lf) begin
                    beat = 0;
                    mptr = W'((int'(o_z_s) + 1) % M);
                end else begin
                    beat++;
                end
            end
            if (!o_busy && (|i_a_v)) exp_grant = rr_model(mptr, i_a_v);
            prev_lastfire = lf;
            prev_busy     = o_busy;
            prev_stall    = o_z_v && !i_z_r;
            prev_s        = o_z_s;
            prev_d        = o_z_d;
        end
    end

    task automatic do_reset(input logic [M-1:0] v);
        @(posedge clk); #1;
        reset_n = 1'b0;
        i_a_v   = v;
        i_z_r   = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_busy(input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy", 64'(o_busy), 64'(1));
    endtask

    task automatic wait_grants(input int cnt, input int maxc);
        int n;
        n = 0;
        while (grants.size() < cnt && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("grant_count", 64'(grants.size() >= cnt), 64'(1));
    endtask

    // From the negedge of a packet's first beat to the negedge of its last beat.
    task automatic pkt_check(input logic [W-1:0] s);
        for (int i = 0; i < L; i++) begin
            check("pkt_v", 64'(o_z_v), 64'(1));
            check("pkt_s", 64'(o_z_s), 64'(s));
            check("pkt_l", 64'(o_z_l), 64'(i == L - 1));
            if (i < L - 1) @(negedge clk);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_v"}, 64'(o_z_v), 64'(0));
        check({tag, "_d"}, 64'(o_z_d), 64'(0));
        check({tag, "_s"}, 64'(o_z_s), 64'(0));
        check({tag, "_l"}, 64'(o_z_l), 64'(0));
        check({tag, "_ar"}, 64'(o_a_r), 64'(0));
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        // Reset with every requester valid: all outputs low.
        reset_n = 1'b0;
        i_a_v   = 4'hF;
        i_z_r   = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1 reset_n = 1'b1;
        wait_busy(10);
        check("first_grant", 64'(o_z_s), 64'(0));

        // All four valid: packets rotate 0,1,2,3,0.
        wait_grants(5, 200);
        if (grants.size() >= 5) begin
            check("rot0", 64'(grants[0]), 64'(0));
            check("rot1", 64'(grants[1]), 64'(1));
            check("rot2", 64'(grants[2]), 64'(2));
            check("rot3", 64'(grants[3]), 64'(3));
            check("rot4", 64'(grants[4]), 64'(0));
        end

        // Single requester 2: 16 beats, one idle cycle, then 2 again.
        do_reset(4'b0100);
        wait_busy(10);
        pkt_check(2);
        @(negedge clk);
        check("single_gap", 64'(o_busy), 64'(0));
        @(negedge clk);
        check("single_again", 64'(o_busy), 64'(1));
        pkt_check(2);

        // ptr now 3; requests on {1,3}: 3, 1, 3.
        @(posedge clk); #1;
        i_a_v = 4'b1010;
        grants.delete();
        wait_grants(3, 200);
        if (grants.size() >= 3) begin
            check("wrap0", 64'(grants[0]), 64'(3));
            check("wrap1", 64'(grants[1]), 64'(1));
            check("wrap2", 64'(grants[2]), 64'(3));
        end

        // Random backpressure and valid drops after each accepted beat.
        repeat (1200) begin
            @(posedge clk); #1;
            i_z_r = 1'($urandom % 2);
            for (int k = 0; k < M; k++) begin
                if (!(i_a_v[k] && !ihs[k])) i_a_v[k] = (($urandom % 4) != 0);
            end
        end
        @(posedge clk); #1;
        i_z_r = 1'b1;
        @(negedge clk);
        for (int k = 0; k < M; k++) begin
            check("sb_count", 64'(exp_seq[k]), 64'(gen_seq[k]));
        end

        // Reset in the middle of a packet from source 1.
        do_reset(4'b0001);
        wait_busy(10);
        check("pre_s0", 64'(o_z_s), 64'(0));
        pkt_check(0);
        @(posedge clk); #1;
        i_a_v = 4'b0010;
        wait_busy(10);
        check("pre_s1", 64'(o_z_s), 64'(1));
        repeat (7) @(negedge clk);
        check("mid_v", 64'(o_z_v), 64'(1));
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        i_a_v = 4'hF;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_busy(10);
        check("post_s", 64'(o_z_s), 64'(0));
        check("post_l", 64'(o_z_l), 64'(0));
        n = 0;
        while (o_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("post_len", 64'(n), 64'(L));

        // L=1, M=3: every beat is last, grant rotates 0,1,2 with an idle cycle between.
        do_reset(4'hF);
        n = 0;
        @(negedge clk);
        while (!l1_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("l1_wait", 64'(l1_busy), 64'(1));
        for (int j = 0; j < 6; j++) begin
            check("l1_s", 64'(l1_zs), 64'(j % 3));
            check("l1_l", 64'(l1_zl), 64'(1));
            check("l1_d", 64'(l1_zd), 64'(8'h10 * (j % 3 + 1)));
            @(negedge clk);
            check("l1_gap", 64'(l1_busy), 64'(0));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
